// File: rtl/deser8_pkg.sv
// Shared constants and types for the deser8 serial-to-parallel receiver.
package deser8_pkg;
  localparam int WORD_W    = 8;
  localparam int BUF_DEPTH = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;
endpackage

// File: rtl/deser8_fifo2.sv
// Two-entry output buffer; a push into a full buffer without a same-cycle pop is dropped.
module deser8_fifo2
  import deser8_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         drop
);

  logic [W-1:0] mem [BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic         full;
  logic         do_pop;
  logic         do_push;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'(BUF_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & full & ~do_pop;
  // When full the write slot coincides with the head, which a same-cycle pop frees.
  assign wr_ptr  = rd_ptr ^ count[0];
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/deser8.sv
// Serial-to-parallel receiver: assembles W strobed bits into a word and queues it in a 2-entry buffer.
module deser8
  import deser8_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 dir,
  input  logic                 sd,
  input  logic                 clr,
  output logic [W-1:0]         q,
  output logic                 q_valid,
  input  logic                 q_ready,
  output logic                 busy,
  output logic [$clog2(W)-1:0] bit_cnt,
  output logic                 ovr
);

  localparam int CW = $clog2(W);

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] asm;
  logic [W-1:0] asm_nxt;
  logic         word_dir;
  logic         cur_dir;
  logic         last_bit;
  logic         push;
  logic         pop;
  logic         drop;
  logic         empty;

  // The first bit of a word uses the live dir; later bits use the latched copy.
  assign cur_dir  = (state == IDLE) ? dir : word_dir;
  assign last_bit = (bit_cnt == CW'(W - 1));
  assign asm_nxt  = cur_dir ? {sd, asm[W-1:1]} : {asm[W-2:0], sd};
  assign push     = en & ~clr & last_bit;
  assign pop      = q_valid & q_ready;
  assign q_valid  = ~empty;
  assign busy     = (state == RECV);

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else if (en) begin
      case (state)
        IDLE:    state_nxt = RECV;
        RECV:    if (last_bit) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      asm      <= '0;
      word_dir <= 1'b0;
      ovr      <= 1'b0;
    end else if (clr) begin
      bit_cnt  <= '0;
      asm      <= '0;
      ovr      <= 1'b0;
    end else begin
      if (en) begin
        if (state == IDLE) word_dir <= dir;
        asm     <= asm_nxt;
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
      if (drop) ovr <= 1'b1;
    end
  end

  deser8_fifo2 #(.W(W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (asm_nxt),
    .dout  (q),
    .empty (empty),
    .drop  (drop)
  );

endmodule

// File: tb/tb_deser8.sv
// Bench for deser8: queue-based reference model compared every cycle, plus directed literal checks.
module tb_deser8;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         dir = 1'b0;
  logic         sd = 1'b0;
  logic         clr = 1'b0;
  logic         q_ready = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic         busy;
  logic [2:0]   bit_cnt;
  logic         ovr;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] mq[$];
  logic         mbits[$];
  logic         mdir;
  logic         movr;
  logic [W-1:0] mw;

  deser8 dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .dir     (dir),
    .sd      (sd),
    .clr     (clr),
    .q       (q),
    .q_valid (q_valid),
    .q_ready (q_ready),
    .busy    (busy),
    .bit_cnt (bit_cnt),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer as a queue of words, partial word as a queue of bits.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mbits.delete();
      mdir = 1'b0;
      movr = 1'b0;
    end else begin
      if (mq.size() > 0 && q_ready) void'(mq.pop_front());
      if (clr) begin
        mbits.delete();
        movr = 1'b0;
      end else if (en) begin
        if (mbits.size() == 0) mdir = dir;
        mbits.push_back(sd);
        if (mbits.size() == W) begin
          mw = '0;
          for (int i = 0; i < W; i++) begin
            if (mdir) mw[i] = mbits[i];
            else      mw[W-1-i] = mbits[i];
          end
          if (mq.size() < 2) mq.push_back(mw);
          else               movr = 1'b1;
          mbits.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("q_valid", 32'(q_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) check("q", 32'(q), 32'(mq[0]));
      check("busy", 32'(busy), 32'(mbits.size() > 0));
      check("bit_cnt", 32'(bit_cnt), 32'(mbits.size()));
      check("ovr", 32'(ovr), 32'(movr));
    end
  end

  task automatic send_bits(input logic [W-1:0] v, input logic lsb, input int n);
    for (int i = 0; i < n; i++) begin
      en  = 1'b1;
      dir = lsb;
      sd  = lsb ? v[i] : v[W-1-i];
      @(negedge clk);
    end
    en = 1'b0;
  endtask

  task automatic pop_one();
    q_ready = 1'b1;
    @(negedge clk);
    q_ready = 1'b0;
  endtask

  logic [W-1:0] v;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_q_valid", 32'(q_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_bit_cnt", 32'(bit_cnt), 0);
    check("rst_ovr", 32'(ovr), 0);
    check("rst_q", 32'(q), 0);
    reset  = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // LSB-first byte with bit counter progression
    q_ready = 1'b1;
    v = 8'hA5;
    for (int i = 0; i < W; i++) begin
      en = 1'b1; dir = 1'b1; sd = v[i];
      @(negedge clk);
      if (i < W - 1) check("lsb_bit_cnt", 32'(bit_cnt), 32'(i + 1));
    end
    en = 1'b0;
    check("lsb_q_valid", 32'(q_valid), 1);
    check("lsb_q", 32'(q), 32'h A5);
    check("lsb_bit_cnt_wrap", 32'(bit_cnt), 0);
    @(negedge clk);
    check("lsb_popped", 32'(q_valid), 0);
    q_ready = 1'b0;

    // MSB-first with dir flipped after the third bit
    v = 8'hC3;
    for (int i = 0; i < W; i++) begin
      en = 1'b1; dir = (i < 3) ? 1'b0 : 1'b1; sd = v[W-1-i];
      @(negedge clk);
    end
    en = 1'b0;
    check("msb_q", 32'(q), 32'h C3);
    pop_one();
    check("msb_popped", 32'(q_valid), 0);

    // Back-pressure and overrun
    send_bits(8'h11, 1'b1, W);
    send_bits(8'h22, 1'b1, W);
    send_bits(8'h33, 1'b1, W);
    check("ovr_set", 32'(ovr), 1);
    check("ovr_head", 32'(q), 32'h11);
    pop_one();
    check("ovr_second", 32'(q), 32'h22);
    pop_one();
    check("ovr_empty", 32'(q_valid), 0);
    check("ovr_sticky", 32'(ovr), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("ovr_cleared", 32'(ovr), 0);

    // Full buffer with simultaneous push and pop
    send_bits(8'h11, 1'b1, W);
    send_bits(8'h22, 1'b1, W);
    v = 8'h44;
    send_bits(v, 1'b1, W - 1);
    en = 1'b1; dir = 1'b1; sd = v[W-1]; q_ready = 1'b1;
    @(negedge clk);
    en = 1'b0; q_ready = 1'b0;
    check("pp_ovr", 32'(ovr), 0);
    check("pp_head", 32'(q), 32'h22);
    pop_one();
    check("pp_next", 32'(q), 32'h44);
    pop_one();
    check("pp_empty", 32'(q_valid), 0);

    // clr mid-word with en asserted
    send_bits(8'h66, 1'b1, W);
    send_bits(8'h0F, 1'b1, 4);
    en = 1'b1; clr = 1'b1; sd = 1'b1;
    @(negedge clk);
    en = 1'b0; clr = 1'b0;
    check("clr_bit_cnt", 32'(bit_cnt), 0);
    check("clr_busy", 32'(busy), 0);
    send_bits(8'h77, 1'b0, W);
    check("clr_kept", 32'(q), 32'h66);
    pop_one();
    check("clr_clean", 32'(q), 32'h77);
    pop_one();

    // Asynchronous reset mid-word
    send_bits(8'h12, 1'b1, W);
    send_bits(8'hFF, 1'b1, 5);
    #2 reset = 1'b1;
    #1;
    check("arst_q_valid", 32'(q_valid), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_bit_cnt", 32'(bit_cnt), 0);
    check("arst_ovr", 32'(ovr), 0);
    check("arst_q", 32'(q), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_bits(8'h5A, 1'b0, W);
    check("arst_after", 32'(q), 32'h5A);
    pop_one();

    // Randomized traffic with varying consumer pressure
    for (int c = 0; c < 3000; c++) begin
      en      = ($urandom_range(0, 3) != 0);
      sd      = 1'($urandom);
      dir     = 1'($urandom);
      clr     = ($urandom_range(0, 79) == 0);
      q_ready = ((c / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    en = 1'b0; clr = 1'b0; q_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/deser8.md
# deser8

Downstream companion to the 8-bit shift register: a serial-to-parallel receiver that consumes the one-bit-per-strobe stream emerging from the shift register's end bit and reassembles it into bytes. Captured bytes queue in a 2-entry output buffer and leave through a valid/ready handshake. An explicit frame-restart input and a sticky overrun flag are provided.

## Interface
- W, 8: word width; the bit counter is sized to hold 0..W-1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  bit strobe; `sd` is valid in cycles where en=1.
- dir  in  1  bit order: 1 = LSB first (matches the upstream shift-right mode), 0 = MSB first.
- sd  in  1  serial data bit.
- clr  in  1  synchronous frame restart: discards the partial word and clears ovr.
- q  out  W  head word of the output buffer.
- q_valid  out  1  output buffer is non-empty.
- q_ready  in  1  consumer accepts `q` when q_valid and q_ready are both 1.
- busy  out  1  a partial word is in progress (state RECV).
- bit_cnt  out  3  number of bits captured in the current word.
- ovr  out  1  sticky overrun flag.

## Operation
- FSM states:
  - IDLE: bit_cnt=0, no partial word. en=1 moves to RECV.
  - RECV: a partial word is held.
- First bit of a word (en=1 while in IDLE):
  - dir is latched into word_dir.
  - word_dir is used for all W bits of that word, even if dir changes mid-word.
- Each en=1 cycle (clr=0) shifts into the assembly register `asm`:
  - word_dir=1: asm <= {sd, asm[W-1:1]}.
  - word_dir=0: asm <= {asm[W-2:0], sd}.
  - bit_cnt increments by 1.
- Completion (en=1 with bit_cnt=W-1):
  - The shifted value, including the current bit, is pushed into the buffer on the same edge.
  - bit_cnt wraps to 0 and the FSM returns to IDLE.
- Output buffer:
  - 2-entry FIFO; q shows the oldest entry.
  - A pop occurs when q_valid and q_ready are both 1.
- Simultaneous push and pop:
  - Always accepted, including when the buffer is full; occupancy is unchanged.
- Push into a full buffer with no pop in the same cycle:
  - The new word is dropped.
  - ovr is set to 1.
  - Buffer contents are unchanged.
- ovr stays at 1 until reset or clr.
- clr=1:
  - bit_cnt <= 0, state <= IDLE, asm <= 0, ovr <= 0.
  - Buffer contents are not flushed, and pops still proceed in that cycle.
- clr and en in the same cycle: clr wins and the bit is discarded.
- en=0: asm, bit_cnt and state hold.
- Reset values: q=0, q_valid=0, busy=0, bit_cnt=0, ovr=0, buffer empty, asm=0, word_dir=0.
- Reset mid-word: the partial word and all buffered words are lost.

## Timing
- Throughput: one bit per cycle, i.e. one word every W strobes, with no dead cycle between consecutive words.
- Latency: word completes at edge N with the buffer empty → q_valid=1 and q valid after edge N. There is no combinational path from en/sd to q.
- The bit-W strobe may immediately follow the previous word's completion strobe.
- q_ready → q_valid: registered effect only. A pop at edge N exposes the next entry, or deasserts q_valid, after edge N.
- All outputs are registered except q, which is a mux of registered entries selected by a registered read pointer.
- q is stable while q_valid=1 and q_ready=0.

## Structure
- Shared package holds:
  - WORD_W = 8.
  - State enum {IDLE, RECV}.
  - Buffer depth constant = 2.
- Sub-module deser8_fifo2: 2-entry FIFO with push/pop/full/empty and an overflow-drop indication. It is instantiated once.
- Top level holds the FSM, bit counter, assembly register and ovr logic.

## Test plan
- **LSB-first byte:** dir=1; sd stream 1,0,1,0,0,1,0,1 on 8 consecutive en cycles; q_ready=1.
  - Required: q=8'hA5 with q_valid=1 for one cycle after the 8th edge.
  - Required: bit_cnt steps 1..7 then back to 0.
- **MSB-first byte with mid-word dir change:** dir=0 at the first bit, dir toggled after bit 3; stream 1,1,0,0,0,0,1,1.
  - Required: q=8'hC3, because word_dir is latched.
- **Back-pressure and overrun:** q_ready=0; send 3 words 8'h11, 8'h22, 8'h33.
  - Required: ovr=1 after the third completion.
  - Required: popping yields 11 then 22; 33 is dropped.
  - Required: a following clr returns ovr to 0.
- **Full buffer, simultaneous push and pop:** buffer holds 11, 22; word 44 completes on the same edge q_ready=1.
  - Required: ovr stays 0 and the pop order is 22, 44.
- **clr mid-word:** 4 bits sent, then clr=1 with en=1.
  - Required: bit_cnt=0 and busy=0; the next 8 bits form a clean word; a pre-existing buffered word is still delivered.
- **Asynchronous reset mid-word:** assert reset between clock edges with 5 bits in progress and 1 word buffered.
  - Required: q_valid, busy, bit_cnt, ovr and q all go to 0 immediately, without waiting for a clock edge.
  - Required: after release, a full byte 8'h5A is received correctly.
